// File: rtl/window_control_if.sv
// Request, register-file and backing-memory signals of the window sequencer.
interface window_control_if #(
  parameter int unsigned NWIN = 4
) ();
  localparam int unsigned WW = $clog2(NWIN);

  logic            save;
  logic            restore;
  logic            wim_we;
  logic [NWIN-1:0] wim_in;
  logic [4:0]      cwp_o;
  logic [NWIN-1:0] wim_o;
  logic [4:0]      rf_b;
  logic [4:0]      rf_a;
  logic            rfe;
  logic            mem_req;
  logic            mem_we;
  logic [WW+3:0]   mem_addr;
  logic            mem_ack;
  logic            busy;
  logic            done;
  logic            illegal;

  modport master (
    output save, restore, wim_we, wim_in, mem_ack,
    input  cwp_o, wim_o, rf_b, rf_a, rfe, mem_req, mem_we, mem_addr,
           busy, done, illegal
  );

  modport slave (
    input  save, restore, wim_we, wim_in, mem_ack,
    output cwp_o, wim_o, rf_b, rf_a, rfe, mem_req, mem_we, mem_addr,
           busy, done, illegal
  );
endinterface

// File: rtl/window_control.sv
// SPARC register-window sequencer: CWP/WIM, SAVE/RESTORE, spill/fill to memory.
// Optional overflow/underflow counters under WINCTL_STATS_EN.
module window_control #(
  parameter int unsigned NWIN = 4,
  parameter int unsigned NREG = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  window_control_if.slave  bus
`ifdef WINCTL_STATS_EN
  ,
  output logic [7:0]       ovf_cnt,
  output logic [7:0]       unf_cnt
`endif
);
  localparam int unsigned WW = $clog2(NWIN);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SPILL  = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0]      state;
  logic [WW-1:0]   cwp;
  logic [NWIN-1:0] wim;
  logic [WW-1:0]   tgt;
  logic [3:0]      k;
  logic            illegal_q;

  logic [WW-1:0]   cwp_dn;
  logic [WW-1:0]   cwp_up;
  logic            last_beat;

  // NWIN is a power of two, so plain wrap-around gives the modulo.
  assign cwp_dn    = cwp - 1'b1;
  assign cwp_up    = cwp + 1'b1;
  assign last_beat = (k == 4'(NREG - 1));

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state     <= IDLE;
      cwp       <= '0;
      wim       <= NWIN'(1) << (NWIN - 1);
      tgt       <= '0;
      k         <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wim_we) begin
            wim <= bus.wim_in;
          end else if (bus.save && bus.restore) begin
            illegal_q <= 1'b1;
          end else if (bus.save) begin
            if (wim[cwp_dn]) begin
              tgt   <= cwp_dn;
              k     <= '0;
              state <= SPILL;
            end else begin
              cwp   <= cwp_dn;
              state <= COMMIT;
            end
          end else if (bus.restore) begin
            if (wim[cwp_up]) begin
              tgt   <= cwp_up;
              k     <= '0;
              state <= FILL;
            end else begin
              cwp   <= cwp_up;
              state <= COMMIT;
            end
          end
        end
        SPILL: begin
          if (bus.mem_ack) begin
            if (last_beat) begin
              k     <= '0;
              cwp   <= tgt;
              wim   <= {wim[0], wim[NWIN-1:1]};
              state <= COMMIT;
            end else begin
              k <= k + 4'd1;
            end
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            if (last_beat) begin
              k     <= '0;
              cwp   <= tgt;
              wim   <= {wim[NWIN-2:0], wim[NWIN-1]};
              state <= COMMIT;
            end else begin
              k <= k + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cwp_o    = 5'(cwp);
    bus.wim_o    = wim;
    bus.rf_b     = '0;
    bus.rf_a     = '0;
    bus.rfe      = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.busy     = (state != IDLE);
    bus.done     = (state == COMMIT);
    bus.illegal  = illegal_q;
    if (state == SPILL) begin
      bus.cwp_o    = 5'(tgt);
      bus.rf_b     = 5'd16 + 5'(k);
      bus.mem_req  = 1'b1;
      bus.mem_we   = 1'b1;
      bus.mem_addr = {tgt, k};
    end else if (state == FILL) begin
      bus.cwp_o    = 5'(tgt);
      bus.rf_a     = 5'd16 + 5'(k);
      bus.rfe      = bus.mem_ack;
      bus.mem_req  = 1'b1;
      bus.mem_addr = {tgt, k};
    end
  end

`ifdef WINCTL_STATS_EN
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (bus.mem_ack && last_beat) begin
      if (state == SPILL && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (state == FILL  && unf_cnt != 8'hFF) unf_cnt <= unf_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_window_control.sv
// Randomized bench for window_control against a transaction-level window model.
module tb_window_control;
  localparam int NWIN = 4;
  localparam int NREG = 16;

  logic Clk = 1'b0;
  logic Clr = 1'b0;
  always #5 Clk = ~Clk;

  window_control_if #(.NWIN(NWIN)) bus ();

`ifdef WINCTL_STATS_EN
  logic [7:0] ovf_cnt, unf_cnt;
`endif

  window_control #(.NWIN(NWIN), .NREG(NREG)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
`ifdef WINCTL_STATS_EN
    ,
    .ovf_cnt (ovf_cnt),
    .unf_cnt (unf_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0 = idle, 1 = moving registers, 2 = commit.
  int m_phase, m_cwp, m_wim, m_tgt, m_beat, m_dir, m_ill, m_ovf, m_unf;

  task automatic m_reset();
    m_phase = 0; m_cwp = 0; m_wim = 8; m_tgt = 0; m_beat = 0;
    m_dir = 0; m_ill = 0; m_ovf = 0; m_unf = 0;
  endtask

  function automatic int rot_r(int w);
    return (w >> 1) | ((w & 1) << (NWIN - 1));
  endfunction

  function automatic int rot_l(int w);
    return ((w << 1) | (w >> (NWIN - 1))) & ((1 << NWIN) - 1);
  endfunction

  task automatic m_step();
    int nb;
    if (!Clr) return;
    m_ill = 0;
    case (m_phase)
      0: begin
        if (bus.wim_we) m_wim = int'(bus.wim_in);
        else if (bus.save && bus.restore) m_ill = 1;
        else if (bus.save || bus.restore) begin
          m_dir = bus.save ? -1 : 1;
          nb = (m_cwp + m_dir + NWIN) % NWIN;
          if (((m_wim >> nb) & 1) == 1) begin
            m_tgt = nb; m_beat = 0; m_phase = 1;
          end else begin
            m_cwp = nb; m_phase = 2;
          end
        end
      end
      1: begin
        if (bus.mem_ack) begin
          if (m_beat == NREG - 1) begin
            m_cwp = m_tgt;
            if (m_dir < 0) begin
              m_wim = rot_r(m_wim);
              if (m_ovf < 255) m_ovf++;
            end else begin
              m_wim = rot_l(m_wim);
              if (m_unf < 255) m_unf++;
            end
            m_phase = 2;
          end else m_beat++;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  function automatic logic [30:0] exp_vec();
    logic [4:0] c, rb, ra;
    logic rfe, req, we;
    logic [5:0] addr;
    bit mv;
    mv   = (m_phase == 1);
    c    = mv ? 5'(m_tgt) : 5'(m_cwp);
    rb   = (mv && m_dir < 0) ? 5'(16 + m_beat) : 5'd0;
    ra   = (mv && m_dir > 0) ? 5'(16 + m_beat) : 5'd0;
    rfe  = mv && m_dir > 0 && bus.mem_ack;
    req  = mv;
    we   = mv && m_dir < 0;
    addr = mv ? 6'(m_tgt * 16 + m_beat) : 6'd0;
    return {c, 4'(m_wim), rb, ra, rfe, req, we, addr,
            1'(m_phase != 0), 1'(m_phase == 2), 1'(m_ill)};
  endfunction

  task automatic compare();
    logic [30:0] act, expv;
    act = {bus.cwp_o, bus.wim_o, bus.rf_b, bus.rf_a, bus.rfe, bus.mem_req,
           bus.mem_we, bus.mem_addr, bus.busy, bus.done, bus.illegal};
    expv = exp_vec();
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, expv);
    end
`ifdef WINCTL_STATS_EN
    vectors++;
    if (ovf_cnt !== 8'(m_ovf) || unf_cnt !== 8'(m_unf)) begin
      miscompares++;
      $display("FAIL stats t=%0t actual=%0d/%0d required=%0d/%0d",
               $time, ovf_cnt, unf_cnt, m_ovf, m_unf);
    end
`endif
  endtask

  task automatic pin(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // One clock: model absorbs the edge, new inputs are driven, outputs checked.
  task automatic cyc(input bit s, input bit r, input bit we,
                     input logic [3:0] win, input bit ack, input bit clr);
    @(posedge Clk);
    m_step();
    @(negedge Clk);
    bus.save = s; bus.restore = r; bus.wim_we = we;
    bus.wim_in = win; bus.mem_ack = ack; Clr = clr;
    if (!clr) m_reset();
    #1;
    compare();
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 4'h0, 0, 0);
    cyc(0, 0, 0, 4'h0, 0, 0);
    cyc(0, 0, 0, 4'h0, 0, 1);
  endtask

  initial begin
    int n;
    bit seen;
    bus.save = 0; bus.restore = 0; bus.wim_we = 0; bus.wim_in = '0; bus.mem_ack = 0;
    m_reset();
    #2;

    do_reset();
    pin("reset_cwp", bus.cwp_o, 0);
    pin("reset_wim", bus.wim_o, 8);
    pin("reset_busy_req_done", {bus.busy, bus.mem_req, bus.done}, 0);

    // Restore without trap.
    cyc(0, 1, 0, 4'h0, 0, 1);
    cyc(0, 0, 0, 4'h0, 0, 1);
    pin("restore_cwp", bus.cwp_o, 1);
    pin("restore_done_busy", {bus.done, bus.busy}, 3);
    cyc(0, 0, 0, 4'h0, 0, 1);
    pin("restore_idle", bus.busy, 0);

    // Overflow spill with ack tied high; a save during the spill is ignored.
    do_reset();
    cyc(1, 0, 0, 4'h0, 1, 1);
    for (int i = 0; i < NREG; i++) begin
      cyc(i == 4, 0, 0, 4'h0, 1, 1);
      pin("spill_addr", bus.mem_addr, 'h30 + i);
      pin("spill_rfb", bus.rf_b, 16 + i);
      pin("spill_cwp_we", {bus.cwp_o, bus.mem_we}, 7);
    end
    cyc(0, 0, 0, 4'h0, 0, 1);
    pin("spill_done", bus.done, 1);
    pin("spill_cwp", bus.cwp_o, 3);
    pin("spill_wim", bus.wim_o, 4);
    cyc(0, 0, 0, 4'h0, 0, 1);
    pin("spill_idle", bus.busy, 0);

    // Underflow fill with ack every third cycle.
    do_reset();
    cyc(0, 0, 1, 4'h2, 0, 1);
    cyc(0, 1, 0, 4'h0, 0, 1);
    n = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc(0, 0, 0, 4'h0, (i % 3) == 2, 1);
      if (bus.rfe) begin
        pin("fill_rfa", bus.rf_a, 16 + n);
        pin("fill_addr", bus.mem_addr, 'h10 + n);
        n++;
      end
      if (bus.done) seen = 1;
    end
    pin("fill_done_seen", seen, 1);
    pin("fill_rfe_count", n, 16);
    pin("fill_cwp", bus.cwp_o, 1);
    pin("fill_wim", bus.wim_o, 4);

    // Illegal request.
    cyc(0, 0, 0, 4'h0, 0, 1);
    cyc(1, 1, 0, 4'h0, 0, 1);
    cyc(0, 0, 0, 4'h0, 0, 1);
    pin("illegal_pulse", bus.illegal, 1);
    pin("illegal_state", {bus.cwp_o, bus.wim_o, bus.busy}, (1 << 5) | (4 << 1));

    // Reset at spill beat 5.
    do_reset();
    cyc(1, 0, 0, 4'h0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 4'h0, 1, 1);
    cyc(0, 0, 0, 4'h0, 0, 1);
    pin("abort_at_k5", bus.mem_addr, 'h35);
    cyc(0, 0, 0, 4'h0, 0, 0);
    pin("abort_req_busy", {bus.mem_req, bus.busy}, 0);
    pin("abort_cwp_wim", {bus.cwp_o, bus.wim_o}, 8);
    cyc(0, 0, 0, 4'h0, 0, 1);
    cyc(0, 0, 0, 4'h0, 0, 1);
    pin("abort_no_done", bus.done, 0);

    // Randomized traffic.
    for (int i = 0; i < 5000; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2) != 0, $urandom_range(0, 399) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
